// File: rtl/game_link_pkg.sv
// Shared constants and types for the inter-board game link (RX decoder and TX framer).
// Packet: SYNC, TYPE, DATA, CHK where CHK = TYPE ^ DATA.
package game_link_pkg;

    localparam logic [7:0] LINK_SYNC = 8'hA5;
    localparam logic [7:0] TYPE_HP   = 8'h01;
    localparam logic [7:0] TYPE_HIT  = 8'h02;
    localparam logic [7:0] HP_MAX    = 8'd100;

    typedef enum logic [1:0] {
        IDLE,
        GOT_SYNC,
        GOT_TYPE,
        GOT_DATA
    } link_state_e;

    function automatic logic [7:0] sat_hp(input logic [7:0] value, input logic [7:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/game_link_rx_link_timer.sv
// Saturating up-counter with synchronous clear and enable; done is high while the count sits at MAX.
module link_timer #(
    parameter int unsigned MAX = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int W = (MAX < 2) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != W'(MAX))) begin
            count <= count + W'(1);
        end
    end

    assign done = (count == W'(MAX));

endmodule

// File: rtl/game_link_rx.sv
// Game link receiver: decodes SYNC/TYPE/DATA/CHK packets from the UART RX core into HP and hit events.
// Optional build macro GAME_LINK_STATS_EN adds a saturating err_count output.
module game_link_rx
    import game_link_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT = 100000,
    parameter int unsigned LINK_LOSS    = 65000000,
    parameter logic [7:0]  HP_INIT      = HP_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] HP_enemy_state,
    output logic       tank_enemy_hit_us,
    output logic       pkt_err,
    output logic       link_alive
`ifdef GAME_LINK_STATS_EN
    ,
    output logic [7:0] err_count
`endif
);

    link_state_e state_q, state_d;
    logic [7:0]  type_q, data_q;
    logic        byte_done, link_done;
    logic        acc_hp, acc_hit, err;
    logic        chk_ok;

    link_timer #(.MAX(BYTE_TIMEOUT)) u_byte_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (rx_valid),
        .en   (state_q != IDLE),
        .done (byte_done)
    );

    // Any accepted packet, HP or HIT, proves the link is up.
    link_timer #(.MAX(LINK_LOSS)) u_link_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_hp | acc_hit),
        .en   (1'b1),
        .done (link_done)
    );

    assign chk_ok = (rx_data == (type_q ^ data_q));

    // NOTE: every output of this block gets a default first so no latch is inferred on idle paths.
    always_comb begin
        state_d = state_q;
        acc_hp  = 1'b0;
        acc_hit = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE:     if (rx_valid && (rx_data == LINK_SYNC)) state_d = GOT_SYNC;
            GOT_SYNC: if (rx_valid) state_d = GOT_TYPE;
            GOT_TYPE: if (rx_valid) state_d = GOT_DATA;
            GOT_DATA: begin
                if (rx_valid) begin
                    state_d = IDLE;
                    if (chk_ok && (type_q == TYPE_HP))       acc_hp  = 1'b1;
                    else if (chk_ok && (type_q == TYPE_HIT)) acc_hit = 1'b1;
                    else                                     err     = 1'b1;
                end
            end
            default:  state_d = IDLE;
        endcase
        // A byte arriving in the timeout cycle takes priority over abandoning the packet.
        if ((state_q != IDLE) && !rx_valid && byte_done) begin
            state_d = IDLE;
            err     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            type_q            <= '0;
            data_q            <= '0;
            HP_enemy_state    <= HP_INIT;
            tank_enemy_hit_us <= 1'b0;
            pkt_err           <= 1'b0;
            link_alive        <= 1'b0;
        end else begin
            state_q           <= state_d;
            tank_enemy_hit_us <= acc_hit;
            pkt_err           <= err;
            if (rx_valid && (state_q == GOT_SYNC)) type_q <= rx_data;
            if (rx_valid && (state_q == GOT_TYPE)) data_q <= rx_data;

            if (acc_hp || acc_hit) link_alive <= 1'b1;
            else if (link_done)    link_alive <= 1'b0;

            if (acc_hp)                     HP_enemy_state <= sat_hp(data_q, HP_INIT);
            else if (link_done && !acc_hit) HP_enemy_state <= HP_INIT;
        end
    end

`ifdef GAME_LINK_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count <= '0;
        end else if (pkt_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: doc/game_link_rx.md
Name: game_link_rx

Overview:
- Decodes the inter-board game link byte stream delivered by the UART receiver into game events.
- Produces the opponent's HP value `HP_enemy_state` and a one-cycle "enemy hit us" pulse `tank_enemy_hit_us` for the HP/overlay stage.
- It is the receive end of the link on which each board reports its own HP and its hits on the opponent.
- Sits between the UART RX core and the HP/overlay stage.

Parameters:
- BYTE_TIMEOUT, 100000, max clk cycles allowed between consecutive bytes of one packet before the packet is abandoned.
- LINK_LOSS, 65000000, clk cycles without a valid packet before `link_alive` drops.
- HP_INIT, 100, reset and link-loss value of `HP_enemy_state`.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- rx_data  in  8  byte from the UART RX core.
- rx_valid  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- HP_enemy_state  out  8  last accepted opponent HP.
- tank_enemy_hit_us  out  1  one-cycle pulse per accepted HIT packet.
- pkt_err  out  1  one-cycle pulse on checksum, type or timeout error.
- link_alive  out  1  high while valid packets arrive within LINK_LOSS.

Behaviour:
- Packet format: 4 bytes, in order SYNC = 0xA5, TYPE, DATA, CHK.
  - CHK = TYPE ^ DATA.
  - TYPE 0x01 = HP update; DATA is the HP value.
  - TYPE 0x02 = HIT; DATA is ignored.
- FSM states: IDLE, GOT_SYNC, GOT_TYPE, GOT_DATA. State advances only on `rx_valid`.
  - IDLE: byte == 0xA5 goes to GOT_SYNC; any other byte is discarded silently (no `pkt_err`).
  - GOT_SYNC: latch TYPE, go to GOT_TYPE. TYPE is validated only at CHK time.
  - GOT_TYPE: latch DATA, go to GOT_DATA.
  - GOT_DATA: the byte is CHK, then return to IDLE.
    - CHK matches and TYPE is 0x01 or 0x02: packet accepted.
    - Otherwise: `pkt_err` = 1 for one cycle.
- Accept latency: outputs update on the clk edge after the cycle in which CHK is presented with `rx_valid`.
- HP update: `HP_enemy_state` <= DATA, saturated to HP_INIT if DATA > HP_INIT.
- HIT: `tank_enemy_hit_us` = 1 for exactly one cycle. Two HIT packets always give two separate pulses, since packets are at least 4 `rx_valid` strobes apart.
- A 0xA5 byte in the TYPE/DATA/CHK positions is treated as data. There is no resynchronisation mid-packet.
- Byte timer:
  - Cleared on every `rx_valid`; counts while the FSM is not in IDLE.
  - On reaching BYTE_TIMEOUT the FSM returns to IDLE and `pkt_err` pulses.
  - If timeout and `rx_valid` fall in the same cycle, the byte wins and the timer clears.
- Link timer:
  - Cleared on each accepted packet; saturates at LINK_LOSS.
  - At LINK_LOSS: `link_alive` <= 0 and `HP_enemy_state` <= HP_INIT.
  - The next accepted packet sets `link_alive` <= 1.
- Reset values: FSM IDLE, both timers 0, `HP_enemy_state` = HP_INIT, `tank_enemy_hit_us` = 0, `pkt_err` = 0, `link_alive` = 0.
- Reset asserted mid-packet discards the partial packet immediately (asynchronous).
- All outputs are registered.

Optional Feature:
- Macro GAME_LINK_STATS_EN.
- Defined: adds output port `err_count` [7:0].
  - Increments on every `pkt_err` pulse and saturates at 255.
  - Reset value 0.
- Undefined: the port and its counter do not exist; all other behaviour is unchanged.

Decomposition:
- Package `game_link_pkg` holds:
  - LINK_SYNC = 8'hA5, TYPE_HP = 8'h01, TYPE_HIT = 8'h02;
  - the FSM state enum;
  - HP_MAX = 100.
- The matching TX framer uses the same package.
- One sub-module, `link_timer`: a parameterised saturating counter with clear and enable inputs and a terminal-count flag. It is instantiated twice (byte timeout and link loss).

Test Plan:
- Send A5 01 3C 3D -> `HP_enemy_state` = 60 one cycle after CHK; `link_alive` = 1; no `pkt_err`.
- Send A5 02 00 02 twice back-to-back -> exactly two one-cycle `tank_enemy_hit_us` pulses; `HP_enemy_state` unchanged.
- Send A5 01 3C 00 (bad CHK) -> one `pkt_err` pulse; `HP_enemy_state` unchanged; `err_count` = 1 when GAME_LINK_STATS_EN is defined.
- Send A5 01, then idle for BYTE_TIMEOUT cycles, then A5 01 C8 C9 -> `pkt_err` pulses at the timeout; second packet accepted; `HP_enemy_state` = 100 (200 saturated).
- Send bytes 12 34 A5 05 00 05 -> leading garbage ignored silently; unknown TYPE gives one `pkt_err`.
- Accept A5 01 14 15 (HP = 20), then no traffic for LINK_LOSS cycles -> `link_alive` = 0 and `HP_enemy_state` = 100. Asserting `rst` = 0 mid-packet returns all outputs to reset values at once.
